rect_plotter: RTL and testbench

Rectangle fill engine between the game/animation control FSMs and `vga_adapter`. It accepts one rectangle request (origin, size, colour) on a start/busy handshake and emits one pixel write per cycle on the adapter's `x`/`y`/`colour`/`plot` inputs. It replaces the ad-hoc DRAW_X/NEXT_Y counter loops in the control FSMs; those FSMs now issue a request and wait for `done`. A `stall` input allows an external arbiter to share the adapter write port.

---
 rtl/rect_plotter.sv | 127 ++++++++++++
 tb/tb_rect_plotter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// rect_plotter: rectangle fill engine placed in front of vga_adapter.
// Latches one rectangle request on start, then emits one pixel write per
// cycle in row-major order. stall freezes the scan, abort cancels it.
// Build option: define RECT_CLIP_EN to suppress pixels that fall off-screen.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; request inputs are latched here
// DRAW  | scanning the rectangle, one pixel per non-stalled cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module rect_plotter #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int CW      = 3
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic [7:0]    x0,
  input  logic [6:0]    y0,
  input  logic [7:0]    w,
  input  logic [6:0]    h,
  input  logic [CW-1:0] colour,
  input  logic          stall,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          plot,
  output logic [7:0]    vga_x,
  output logic [6:0]    vga_y,
  output logic [CW-1:0] vga_colour
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [8:0] XLIM = 9'(XSCREEN);
  localparam logic [7:0] YLIM = 8'(YSCREEN);

  state_t        state;
  logic [7:0]    x0r;
  logic [6:0]    y0r;
  logic [7:0]    wr;
  logic [6:0]    hr;
  logic [CW-1:0] colr;
  logic [7:0]    cx;
  logic [6:0]    cy;

  logic [8:0]    sum_x;
  logic [7:0]    sum_y;
  logic          in_range;

  // Request latch, scan counters and state sequencing.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= IDLE;
      x0r   <= '0;
      y0r   <= '0;
      wr    <= '0;
      hr    <= '0;
      colr  <= '0;
      cx    <= '0;
      cy    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0r   <= x0;
            y0r   <= y0;
            wr    <= w;
            hr    <= h;
            colr  <= colour;
            cx    <= '0;
            cy    <= '0;
            state <= (w == 8'd0 || h == 7'd0) ? DONE : DRAW;
          end
        end
        DRAW: begin
          if (abort) begin
            state <= IDLE;
          end else if (!stall) begin
            if (cx != wr - 8'd1) begin
              cx <= cx + 8'd1;
            end else if (cy != hr - 7'd1) begin
              cx <= '0;
              cy <= cy + 7'd1;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pixel position is formed with a carry bit so off-screen sums are visible.
  always_comb begin
    sum_x = {1'b0, x0r} + {1'b0, cx};
    sum_y = {1'b0, y0r} + {1'b0, cy};
  end

`ifdef RECT_CLIP_EN
  // Suppress writes whose untruncated position lies outside the screen.
  always_comb begin
    in_range = (sum_x < XLIM) && (sum_y < YLIM);
  end
`else
  // Without clipping the adapter sees every pixel; wrap is its concern.
  logic unused_sum_bits;
  always_comb begin
    in_range        = 1'b1;
    unused_sum_bits = sum_x[8] ^ sum_y[7] ^ (^XLIM) ^ (^YLIM);
  end
`endif

  // Adapter-facing outputs and handshake flags decoded from current state.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    plot       = (state == DRAW) & ~stall & ~abort & in_range;
    vga_x      = sum_x[7:0];
    vga_y      = sum_y[6:0];
    vga_colour = colr;
  end

endmodule

// File: tb/tb_rect_plotter.sv
`timescale 1ns/1ps
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       resetn, start, stall, abort;
  logic [7:0] x0, w;
  logic [6:0] y0, h;
  logic [2:0] colour;
  logic       busy, done, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  rect_plotter #(.XSCREEN(160), .YSCREEN(120), .CW(3)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .colour(colour),
    .stall(stall), .abort(abort),
    .busy(busy), .done(done), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  typedef struct {
    int x;
    int y;
    bit vis;
  } pix_t;

  typedef struct {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] col;
    int smode;
    int abort_at;
    int gap;
    int exp_plots;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit visible(input int px, input int py);
`ifdef RECT_CLIP_EN
    return (px < 160) && (py < 120);
`else
    return 1'b1;
`endif
  endfunction

  // Issues one request (caller sits just after a rising edge) and follows it
  // cycle by cycle against the row-major pixel list of the rectangle.
  task automatic run_rect(input logic [7:0] xi, input logic [6:0] yi,
                          input logic [7:0] wi, input logic [6:0] hi,
                          input logic [2:0] ci, input int smode,
                          input int abort_at,
                          output int n_plots, output int done_cyc,
                          output int n_stall);
    pix_t q[$];
    pix_t p;
    int   idx;
    int   pc;
    int   limit;
    bit   fin;
    q.delete();
    for (int r = 0; r < int'(hi); r++)
      for (int c = 0; c < int'(wi); c++) begin
        p.x   = (int'(xi) + c) % 256;
        p.y   = (int'(yi) + r) % 128;
        p.vis = visible(int'(xi) + c, int'(yi) + r);
        q.push_back(p);
      end
    idx = 0; pc = 0; fin = 0;
    n_plots = 0; done_cyc = -1; n_stall = 0;
    limit = 2 * q.size() + 10;
    start = 1; x0 = xi; y0 = yi; w = wi; h = hi; colour = ci;
    stall = 0; abort = 0;
    @(negedge CLOCK_50);
    chk("idle_busy", busy, 0);
    chk("idle_plot", plot, 0);
    @(posedge CLOCK_50); #1;
    for (int cyc = 1; cyc <= limit && !fin; cyc++) begin
      start = 1'($urandom_range(0, 1));
      x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom);
      h = 7'($urandom); colour = 3'($urandom);
      stall = 0; abort = 0;
      if (idx < q.size()) begin
        if (smode == 1) stall = (cyc % 2 == 0);
        else if (smode == 2 && n_stall < q.size() + 2)
          stall = ($urandom_range(0, 2) == 0);
        if (abort_at != 0 && pc + 1 == abort_at) abort = 1;
      end
      @(negedge CLOCK_50);
      if (idx < q.size()) begin
        chk("busy_draw", busy, 1);
        chk("done_early", done, 0);
        if (abort) begin
          chk("plot_abort", plot, 0);
          @(posedge CLOCK_50); #1;
          start = 0; stall = 0; abort = 0;
          @(negedge CLOCK_50);
          chk("abort_idle_busy", busy, 0);
          chk("abort_no_done", done, 0);
          fin = 1;
        end else if (stall) begin
          chk("plot_stall", plot, 0);
          n_stall++;
        end else begin
          chk("plot", plot, int'(q[idx].vis));
          if (q[idx].vis) begin
            chk("vga_x", vga_x, q[idx].x);
            chk("vga_y", vga_y, q[idx].y);
            chk("vga_colour", vga_colour, ci);
          end
          if (plot) n_plots++;
          idx++;
          pc++;
        end
      end else begin
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("plot_done", plot, 0);
        done_cyc = cyc;
        fin = 1;
      end
      @(posedge CLOCK_50); #1;
    end
    start = 0; stall = 0; abort = 0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles", limit);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   np, dc, ns, expn;
    logic [7:0] rx, rw;
    logic [6:0] ry, rh;
    logic [2:0] rc;
    int   seen_done;

    vt[0] = '{8'd39,  7'd5,   8'd4, 7'd4, 3'd5, 0, 0, 1, 16, 17};
    vt[1] = '{8'd10,  7'd10,  8'd0, 7'd3, 3'd2, 0, 0, 0, 0,  1};
    vt[2] = '{8'd20,  7'd30,  8'd3, 7'd2, 3'd6, 0, 0, 1, 6,  7};
`ifdef RECT_CLIP_EN
    vt[3] = '{8'd158, 7'd118, 8'd4, 7'd4, 3'd3, 0, 0, 1, 4,  17};
`else
    vt[3] = '{8'd158, 7'd118, 8'd4, 7'd4, 3'd3, 0, 0, 1, 16, 17};
`endif
    vt[4] = '{8'd50,  7'd60,  8'd2, 7'd2, 3'd1, 1, 0, 1, 4,  8};
    vt[5] = '{8'd5,   7'd5,   8'd4, 7'd4, 3'd7, 0, 6, 1, 5,  -1};
    vt[6] = '{8'd0,   7'd0,   8'd1, 7'd1, 3'd4, 0, 0, 1, 1,  2};
    vt[7] = '{8'd100, 7'd50,  8'd5, 7'd0, 3'd2, 0, 0, 1, 0,  1};

    resetn = 0; start = 0; stall = 0; abort = 0;
    x0 = 0; y0 = 0; w = 0; h = 0; colour = 0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    @(posedge CLOCK_50); #1;
    resetn = 1;
    @(posedge CLOCK_50); #1;

    for (int i = 0; i < 8; i++) begin
      run_rect(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].col,
               vt[i].smode, vt[i].abort_at, np, dc, ns);
      chk($sformatf("vec%0d_plots", i), np, vt[i].exp_plots);
      chk($sformatf("vec%0d_done_cycle", i), dc, vt[i].exp_done);
      repeat (vt[i].gap) begin
        @(posedge CLOCK_50); #1;
      end
    end

    for (int i = 0; i < 25; i++) begin
      rx = 8'($urandom); ry = 7'($urandom);
      rw = 8'($urandom_range(0, 12)); rh = 7'($urandom_range(0, 6));
      rc = 3'($urandom);
      expn = 0;
      for (int r = 0; r < int'(rh); r++)
        for (int c = 0; c < int'(rw); c++)
          if (visible(int'(rx) + c, int'(ry) + r)) expn++;
      run_rect(rx, ry, rw, rh, rc, 2, 0, np, dc, ns);
      chk($sformatf("rand%0d_plots", i), np, expn);
      chk($sformatf("rand%0d_done_cycle", i), dc, int'(rw) * int'(rh) + ns + 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLOCK_50); #1;
      end
    end

    // Reset in the middle of a 4x4 rectangle.
    start = 1; x0 = 8'd30; y0 = 7'd40; w = 8'd4; h = 7'd4; colour = 3'd6;
    @(posedge CLOCK_50); #1;
    start = 0;
    @(negedge CLOCK_50);
    chk("pre_rst_plot", plot, 1);
    chk("pre_rst_x", vga_x, 30);
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    resetn = 0;
    @(posedge CLOCK_50); #1;
    resetn = 1;
    @(negedge CLOCK_50);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_plot", plot, 0);
    chk("midrst_x", vga_x, 0);
    chk("midrst_y", vga_y, 0);
    chk("midrst_colour", vga_colour, 0);
    seen_done = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (done || plot) seen_done++;
    end
    chk("midrst_quiet", seen_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
